// File: rtl/shifter_sequencer.sv
// Multi-cycle barrel-shifter replacement: decodes the shifter operand of an
// instruction word and produces it by stepping one bit per cycle.
module shifter_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic [31:0] Rm,
  input  logic [31:0] Rs,
  input  logic        c_in,
  output logic [31:0] out,
  output logic        carry_out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX} op_t;

  state_t         state_q, state_d;
  op_t            op_q, op_d, dec_op, type_op;
  logic [CW-1:0]  cnt_q, cnt_d, dec_count;
  logic [DW-1:0]  dec_operand, step_out, out_d;
  logic           cin_q, cin_d, step_carry, carry_d, busy_d, done_d;
  logic [4:0]     imm5;
  logic           reg_form;
  logic           unused_bits;

  assign unused_bits = ^{instruction[31:28], instruction[24], Rs[31:8]};
  assign imm5        = instruction[11:7];
  assign reg_form    = (instruction[27:25] == 3'b000) && instruction[4];

  always_comb begin : type_map
    case (instruction[6:5])
      2'b01:   type_op = OP_LSR;
      2'b10:   type_op = OP_ASR;
      2'b11:   type_op = OP_ROR;
      default: type_op = OP_LSL;
    endcase
  end

  // Operand, step count and step kind chosen from the instruction class.
  always_comb begin : decode
    dec_operand = '0;
    dec_count   = '0;
    dec_op      = OP_LSL;
    case (instruction[27:25])
      3'b001: begin
        dec_operand = {24'd0, instruction[7:0]};
        dec_count   = CW'({instruction[11:8], 1'b0});
        dec_op      = OP_ROR;
      end
      3'b000, 3'b011: begin
        dec_operand = Rm;
        dec_op      = type_op;
        if (reg_form) begin
          if (Rs[7:0] == 8'd0) begin
            dec_count = '0;
          end else begin
            case (instruction[6:5])
              2'b10:   dec_count = (Rs[7:0] > 8'd32) ? CW'(32) : CW'(Rs[7:0]);
              2'b11:   dec_count = (Rs[4:0] == 5'd0) ? CW'(32) : CW'(Rs[4:0]);
              default: dec_count = (Rs[7:0] > 8'd33) ? CW'(33) : CW'(Rs[7:0]);
            endcase
          end
        end else if (imm5 != 5'd0) begin
          dec_count = CW'(imm5);
        end else begin
          case (instruction[6:5])
            2'b00:   dec_count = '0;
            2'b11: begin
              dec_op    = OP_RRX;
              dec_count = CW'(1);
            end
            default: dec_count = CW'(32);
          endcase
        end
      end
      3'b010:  dec_operand = {20'd0, instruction[11:0]};
      3'b101:  dec_operand = {{6{instruction[23]}}, instruction[23:0], 2'b00};
      default: dec_operand = '0;
    endcase
  end

  // One single-bit step of the latched shift kind.
  always_comb begin : step
    step_out   = out;
    step_carry = carry_out;
    case (op_q)
      OP_LSL:  {step_carry, step_out} = {out, 1'b0};
      OP_LSR:  {step_out, step_carry} = {1'b0, out};
      OP_ASR:  {step_out, step_carry} = {out[DW-1], out};
      OP_ROR:  {step_out, step_carry} = {out[0], out};
      OP_RRX:  {step_out, step_carry} = {cin_q, out};
      default: ;
    endcase
  end

  always_comb begin : next_state
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    out_d   = out;
    carry_d = carry_out;
    case (state_q)
      IDLE: begin
        if (start) begin
          out_d   = dec_operand;
          carry_d = c_in;
          cnt_d   = dec_count;
          op_d    = dec_op;
          cin_d   = c_in;
          state_d = (dec_count == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        out_d   = step_out;
        carry_d = step_carry;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge clr) begin : regs
    if (!clr) begin
      state_q   <= IDLE;
      op_q      <= OP_LSL;
      cnt_q     <= '0;
      cin_q     <= 1'b0;
      out       <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      cin_q     <= cin_d;
      out       <= out_d;
      carry_out <= carry_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: doc/shifter_sequencer.md
SHIFTER_SEQUENCER -- requirements
Module: shifter_sequencer

Interface
REQ-001 The block SHALL have the ports below, with clock and reset first.
- clk  input  1  single clock; all state updates on rising edge.
- clr  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- instruction  input  32  instruction word; sampled with start.
- Rm  input  32  operand register value; sampled with start.
- Rs  input  32  shift-amount register; only Rs[7:0] is used, sampled with start.
- c_in  input  1  current C flag; sampled with start.
- out  output  32  shifter operand result; held until the next accepted start.
- carry_out  output  1  shifter carry; held with out.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; out and carry_out are valid in this cycle.
REQ-002 The block SHALL have no parameters.

Function
REQ-003 FSM states SHALL be IDLE, SHIFT and DONE; IDLE -> SHIFT when start=1 and count>0; IDLE -> DONE when start=1 and count=0; SHIFT -> DONE when remaining count=1; DONE -> IDLE unconditionally.
REQ-004 On accept, the block SHALL latch the operand, step count, shift type and c_in; start while busy=1 SHALL be ignored.
REQ-005 Decode on instruction[27:25] SHALL be:
- 001 = imm8 instruction[7:0], ROR by 2*instruction[11:8].
- 000 with bit4=0 = Rm shifted by imm5 instruction[11:7], type instruction[6:5].
- 000 with bit4=1 = Rm shifted by Rs[7:0], type instruction[6:5].
- 010 = zero-extended instruction[11:0].
- 011 = same as 000 with bit4=0.
- 101 = {{6{instruction[23]}}, instruction[23:0], 2'b00}.
- any other value = out 0.
REQ-006 Types SHALL be 00 LSL, 01 LSR, 10 ASR, 11 ROR; each SHIFT cycle performs exactly one 1-bit step, and carry_out takes the bit shifted out.
REQ-007 Immediate-amount count rules:
- LSL #0: count 0, result Rm, carry c_in.
- LSR #0 and ASR #0: count 32.
- ROR #0: RRX, count 1, bit31 <- c_in, carry <- Rm[0].
REQ-008 Register-amount count rules:
- Rs[7:0]=0: count 0, result Rm, carry c_in, for all types.
- LSL/LSR: count = min(Rs[7:0], 33).
- ASR: count = min(Rs[7:0], 32).
- ROR: count = Rs[4:0], or 32 when Rs[4:0]=0 and Rs[7:0]!=0.
REQ-009 Immediate rotate SHALL use count = 2*rot; when rot=0, carry_out = c_in.
REQ-010 Decodes 010, 101 and "other" SHALL use count 0 and carry_out = c_in.
REQ-011 Latency: with count N, done SHALL be high in the cycle starting N+1 rising edges after the accepting edge.
REQ-012 done SHALL be high for exactly one cycle per accepted start, and SHALL be low in IDLE and SHIFT.
REQ-013 start asserted during the DONE cycle SHALL NOT be accepted; the earliest accept is the following edge, in IDLE.
REQ-014 out and carry_out SHALL update only on the accepting edge and during SHIFT/DONE transitions, and SHALL otherwise hold.

Reset
REQ-015 When clr=0, the block SHALL asynchronously force state=IDLE, out=0, carry_out=0, busy=0, done=0 and internal count=0, including mid-SHIFT; the aborted operation SHALL NOT produce done.
REQ-016 After clr deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-017 The bench SHALL cover the directed scenarios below, each with Rm=0xC000000A and c_in=0 unless stated otherwise.
- instruction=0xE1A00100 (LSL #2) -> out=0x00000028, carry_out=1, done on the 3rd edge after accept.
- instruction=0xE1A00020 (LSR #0, executed as #32) -> out=0x00000000, carry_out=1, done after 33 edges.
- instruction=0xE1A00060 (RRX) -> out=0x60000005, carry_out=0, done after 2 edges.
- instruction=0xE3A002FF (imm 0xFF ROR 4) -> out=0xF000000F, carry_out=1, done after 5 edges.
- instruction=0xE1A00110 with Rs=0x00000021 (LSL by 33) -> out=0, carry_out=0; with Rs=0 -> out=Rm, carry_out=c_in, done after 1 edge.
- clr pulsed low during SHIFT -> out=0, carry_out=0 and busy=0 immediately, no done; then start pulsed while busy -> ignored, and the result matches the first request only.
